// File: rtl/tv80_busif.sv
// Bus-cycle controller between tv80_core and a Z80-style bus: registered strobes,
// read-data latch and per-cycle-type wait states. Optional refresh strobe: TV80_BUSIF_REFRESH_EN.
module tv80_busif #(
   parameter int DW        = 8,
   parameter int T2WRITE   = 1,
   parameter int M1_WAIT   = 0,
   parameter int MEM_WAIT  = 0,
   parameter int IO_WAIT   = 1,
   parameter int INTA_WAIT = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cen_i,
   input  logic [6:0]    mcycle_i,
   input  logic [6:0]    tstate_i,
   input  logic          intcycle_n_i,
   input  logic          no_read_i,
   input  logic          write_i,
   input  logic          iorq_i,
   input  logic          wait_n_i,
   input  logic [DW-1:0] di_i,
   output logic          wait_core_n_o,
   output logic          mreq_n_o,
   output logic          iorq_n_o,
   output logic          rd_n_o,
   output logic          wr_n_o,
   output logic [DW-1:0] di_reg_o
);

   typedef enum logic [1:0] {CYC_FETCH, CYC_INTA, CYC_IO, CYC_MEM} cycle_e;

   localparam logic [2:0] M1W   = 3'(M1_WAIT);
   localparam logic [2:0] MEMW  = 3'(MEM_WAIT);
   localparam logic [2:0] IOW   = 3'(IO_WAIT);
   localparam logic [2:0] INTAW = 3'(INTA_WAIT);

   logic [2:0]    wcnt_q, wcnt_d;
   logic          mreq_n_q, mreq_n_d;
   logic          iorq_n_q, iorq_n_d;
   logic          rd_n_q, rd_n_d;
   logic          wr_n_q, wr_n_d;
   logic [DW-1:0] di_reg_q, di_reg_d;
   cycle_e        cycType;
   logic [2:0]    typeWait;
   logic          isM1;
   logic          stretch;
   logic          unusedBits;

   assign unusedBits = ^{mcycle_i[6:1], tstate_i[6:3], tstate_i[0]};

   assign isM1          = mcycle_i[0];
   assign wait_core_n_o = wait_n_i & (wcnt_q == 3'd0);
   assign stretch       = tstate_i[1] | (tstate_i[2] & ~wait_core_n_o);

   always_comb begin
      cycType  = CYC_MEM;
      typeWait = MEMW;
      if (isM1 && intcycle_n_i) begin
         cycType  = CYC_FETCH;
         typeWait = M1W;
      end else if (isM1) begin
         cycType  = CYC_INTA;
         typeWait = INTAW;
      end else if (iorq_i) begin
         cycType  = CYC_IO;
         typeWait = IOW;
      end
   end

   // Every enabled edge starts from "all strobes idle" and then re-asserts whatever
   // the current T-state and cycle type call for, so strobes drop as soon as T2 ends.
   always_comb begin
      wcnt_d   = wcnt_q;
      mreq_n_d = mreq_n_q;
      iorq_n_d = iorq_n_q;
      rd_n_d   = rd_n_q;
      wr_n_d   = wr_n_q;
      di_reg_d = di_reg_q;
      if (cen_i) begin
         mreq_n_d = 1'b1;
         iorq_n_d = 1'b1;
         rd_n_d   = 1'b1;
         wr_n_d   = 1'b1;
         if (tstate_i[1])
            wcnt_d = typeWait;
         else if (tstate_i[2] && wcnt_q != 3'd0)
            wcnt_d = wcnt_q - 3'd1;
         if (cycType == CYC_FETCH || cycType == CYC_INTA) begin
            if (stretch) begin
               rd_n_d   = ~intcycle_n_i;
               mreq_n_d = ~intcycle_n_i;
               iorq_n_d = intcycle_n_i;
            end
`ifdef TV80_BUSIF_REFRESH_EN
            if (tstate_i[3])
               mreq_n_d = 1'b0;
`endif
         end else if (write_i) begin
            if ((T2WRITE != 0) ? stretch : tstate_i[2]) begin
               wr_n_d   = 1'b0;
               iorq_n_d = ~iorq_i;
               mreq_n_d = iorq_i;
            end
         end else if (!no_read_i && stretch) begin
            rd_n_d   = 1'b0;
            iorq_n_d = ~iorq_i;
            mreq_n_d = iorq_i;
         end
         if (tstate_i[2] && wait_core_n_o && !write_i && !no_read_i)
            di_reg_d = di_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wcnt_q   <= 3'd0;
         mreq_n_q <= 1'b1;
         iorq_n_q <= 1'b1;
         rd_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         di_reg_q <= '0;
      end else begin
         wcnt_q   <= wcnt_d;
         mreq_n_q <= mreq_n_d;
         iorq_n_q <= iorq_n_d;
         rd_n_q   <= rd_n_d;
         wr_n_q   <= wr_n_d;
         di_reg_q <= di_reg_d;
      end
   end

   assign mreq_n_o = mreq_n_q;
   assign iorq_n_o = iorq_n_q;
   assign rd_n_o   = rd_n_q;
   assign wr_n_o   = wr_n_q;
   assign di_reg_o = di_reg_q;

endmodule

// File: tb/tb_tv80_busif.sv
// Self-checking bench for tv80_busif: a table of fetch/IO/INTA/write vectors on one
// instance, plus hand-written reset, T2WRITE=0 and clock-enable sequences on a second.
module tb_tv80_busif;

   localparam logic [6:0] M1 = 7'b0000001, M2 = 7'b0000010;
   localparam logic [6:0] T1 = 7'b0000010, T2 = 7'b0000100, T3 = 7'b0001000, T4 = 7'b0010000;
`ifdef TV80_BUSIF_REFRESH_EN
   localparam logic REFRESH = 1'b1;
`else
   localparam logic REFRESH = 1'b0;
`endif

   typedef struct {
      logic       cen;
      logic [6:0] mc;
      logic [6:0] ts;
      logic       intN;
      logic       noRd;
      logic       wr;
      logic       iorq;
      logic       waitN;
      logic [7:0] di;
      logic       eWc;
      logic       eMreq;
      logic       eIorq;
      logic       eRd;
      logic       eWr;
      logic [7:0] eDi;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cen;
   logic [6:0] mcycle, tstate;
   logic       intcycle_n, no_read, write, iorq, wait_n;
   logic [7:0] di;
   logic       wcA, mreqA, iorqA, rdA, wrA;
   logic [7:0] diA;
   logic       wcB, mreqB, iorqB, rdB, wrB;
   logic [7:0] diB;
   int         checks = 0;
   int         passes = 0;
   vec_t       vecs[20];

   always #5 clk = ~clk;

   tv80_busif #(.DW(8), .T2WRITE(1), .M1_WAIT(0), .MEM_WAIT(0), .IO_WAIT(3), .INTA_WAIT(2)) dutA (
      .clk(clk), .reset_n(reset_n), .cen_i(cen), .mcycle_i(mcycle), .tstate_i(tstate),
      .intcycle_n_i(intcycle_n), .no_read_i(no_read), .write_i(write), .iorq_i(iorq),
      .wait_n_i(wait_n), .di_i(di), .wait_core_n_o(wcA), .mreq_n_o(mreqA), .iorq_n_o(iorqA),
      .rd_n_o(rdA), .wr_n_o(wrA), .di_reg_o(diA));

   tv80_busif #(.DW(8), .T2WRITE(0), .M1_WAIT(0), .MEM_WAIT(0), .IO_WAIT(1), .INTA_WAIT(2)) dutB (
      .clk(clk), .reset_n(reset_n), .cen_i(cen), .mcycle_i(mcycle), .tstate_i(tstate),
      .intcycle_n_i(intcycle_n), .no_read_i(no_read), .write_i(write), .iorq_i(iorq),
      .wait_n_i(wait_n), .di_i(di), .wait_core_n_o(wcB), .mreq_n_o(mreqB), .iorq_n_o(iorqB),
      .rd_n_o(rdB), .wr_n_o(wrB), .di_reg_o(diB));

   function automatic vec_t mkVec(input logic c, input logic [6:0] m, input logic [6:0] t,
                                  input logic iN, input logic nr, input logic w, input logic io,
                                  input logic wn, input logic [7:0] d, input logic ewc,
                                  input logic emq, input logic eio, input logic erd,
                                  input logic ewr, input logic [7:0] edi);
      vec_t v;
      v.cen = c; v.mc = m; v.ts = t; v.intN = iN; v.noRd = nr; v.wr = w; v.iorq = io;
      v.waitN = wn; v.di = d; v.eWc = ewc; v.eMreq = emq; v.eIorq = eio; v.eRd = erd;
      v.eWr = ewr; v.eDi = edi;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Drive one clock's worth of inputs at the falling edge, then let the rising edge act.
   task automatic applyStimulus(input logic c, input logic [6:0] m, input logic [6:0] t,
                                input logic iN, input logic nr, input logic w, input logic io,
                                input logic wn, input logic [7:0] d);
      @(negedge clk);
      cen = c; mcycle = m; tstate = t; intcycle_n = iN; no_read = nr; write = w;
      iorq = io; wait_n = wn; di = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // cen mc ts intN noRd wr iorq waitN di  | wc mreq iorq rd wr di
      vecs[0]  = mkVec(1, M1, T1, 1, 0, 0, 0, 1, 8'h3E, 1, 0, 1, 0, 1, 8'h00);
      vecs[1]  = mkVec(1, M1, T2, 1, 0, 0, 0, 1, 8'h3E, 1, 1, 1, 1, 1, 8'h3E);
      vecs[2]  = mkVec(1, M1, T3, 1, 0, 0, 0, 1, 8'h00, 1, ~REFRESH, 1, 1, 1, 8'h3E);
      vecs[3]  = mkVec(1, M1, T4, 1, 0, 0, 0, 1, 8'h00, 1, 1, 1, 1, 1, 8'h3E);
      vecs[4]  = mkVec(1, M2, T1, 1, 0, 0, 1, 1, 8'hA5, 0, 1, 0, 0, 1, 8'h3E);
      vecs[5]  = mkVec(1, M2, T2, 1, 0, 0, 1, 1, 8'hA5, 0, 1, 0, 0, 1, 8'h3E);
      vecs[6]  = mkVec(1, M2, T2, 1, 0, 0, 1, 1, 8'hA5, 0, 1, 0, 0, 1, 8'h3E);
      vecs[7]  = mkVec(1, M2, T2, 1, 0, 0, 1, 1, 8'hA5, 1, 1, 0, 0, 1, 8'h3E);
      vecs[8]  = mkVec(1, M2, T2, 1, 0, 0, 1, 1, 8'hA5, 1, 1, 1, 1, 1, 8'hA5);
      vecs[9]  = mkVec(1, M2, T3, 1, 0, 0, 1, 1, 8'h00, 1, 1, 1, 1, 1, 8'hA5);
      vecs[10] = mkVec(1, M1, T1, 0, 0, 0, 0, 1, 8'hFF, 0, 1, 0, 1, 1, 8'hA5);
      vecs[11] = mkVec(1, M1, T2, 0, 0, 0, 0, 0, 8'hFF, 0, 1, 0, 1, 1, 8'hA5);
      vecs[12] = mkVec(1, M1, T2, 0, 0, 0, 0, 0, 8'hFF, 0, 1, 0, 1, 1, 8'hA5);
      vecs[13] = mkVec(1, M1, T2, 0, 0, 0, 0, 0, 8'hFF, 0, 1, 0, 1, 1, 8'hA5);
      vecs[14] = mkVec(1, M1, T2, 0, 0, 0, 0, 0, 8'hFF, 0, 1, 0, 1, 1, 8'hA5);
      vecs[15] = mkVec(1, M1, T2, 0, 0, 0, 0, 1, 8'hFF, 1, 1, 1, 1, 1, 8'hFF);
      vecs[16] = mkVec(1, M1, T3, 1, 0, 0, 0, 1, 8'h00, 1, ~REFRESH, 1, 1, 1, 8'hFF);
      vecs[17] = mkVec(1, M2, T1, 1, 0, 1, 0, 1, 8'h77, 1, 0, 1, 1, 0, 8'hFF);
      vecs[18] = mkVec(1, M2, T2, 1, 0, 1, 0, 1, 8'h77, 1, 1, 1, 1, 1, 8'hFF);
      vecs[19] = mkVec(1, M2, T3, 1, 0, 1, 0, 1, 8'h77, 1, 1, 1, 1, 1, 8'hFF);

      reset_n = 1'b0; cen = 1'b1; mcycle = 7'd0; tstate = 7'd0; intcycle_n = 1'b1;
      no_read = 1'b0; write = 1'b0; iorq = 1'b0; wait_n = 1'b1; di = 8'h00;
      #12;
      checkOutput("reset mreq_n", {7'd0, mreqA}, 8'd1);
      checkOutput("reset iorq_n", {7'd0, iorqA}, 8'd1);
      checkOutput("reset rd_n", {7'd0, rdA}, 8'd1);
      checkOutput("reset wr_n", {7'd0, wrA}, 8'd1);
      checkOutput("reset di_reg", diA, 8'h00);
      checkOutput("reset wait_core_n", {7'd0, wcA}, 8'd1);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].cen, vecs[i].mc, vecs[i].ts, vecs[i].intN, vecs[i].noRd,
                       vecs[i].wr, vecs[i].iorq, vecs[i].waitN, vecs[i].di);
         checkOutput($sformatf("vec%0d wait_core_n", i), {7'd0, wcA}, {7'd0, vecs[i].eWc});
         checkOutput($sformatf("vec%0d mreq_n", i), {7'd0, mreqA}, {7'd0, vecs[i].eMreq});
         checkOutput($sformatf("vec%0d iorq_n", i), {7'd0, iorqA}, {7'd0, vecs[i].eIorq});
         checkOutput($sformatf("vec%0d rd_n", i), {7'd0, rdA}, {7'd0, vecs[i].eRd});
         checkOutput($sformatf("vec%0d wr_n", i), {7'd0, wrA}, {7'd0, vecs[i].eWr});
         checkOutput($sformatf("vec%0d di_reg", i), diA, vecs[i].eDi);
      end

      // Asynchronous reset while a memory read strobe is active.
      applyStimulus(1, M2, T1, 1, 0, 0, 0, 1, 8'h55);
      checkOutput("midread rd_n low", {7'd0, rdA}, 8'd0);
      checkOutput("midread mreq_n low", {7'd0, mreqA}, 8'd0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset rd_n", {7'd0, rdA}, 8'd1);
      checkOutput("async reset mreq_n", {7'd0, mreqA}, 8'd1);
      checkOutput("async reset di_reg", diA, 8'h00);
      checkOutput("async reset wait_core_n", {7'd0, wcA}, 8'd1);
      @(negedge clk);
      tstate = 7'd0; mcycle = 7'd0;
      reset_n = 1'b1;

      // Memory write with an externally stretched T2: late wr_n on B, early on A.
      applyStimulus(1, M2, T1, 1, 0, 1, 0, 1, 8'h77);
      checkOutput("wrB T1", {7'd0, wrB}, 8'd1);
      checkOutput("wrA T1", {7'd0, wrA}, 8'd0);
      applyStimulus(1, M2, T2, 1, 0, 1, 0, 0, 8'h77);
      checkOutput("wrB T2a", {7'd0, wrB}, 8'd0);
      checkOutput("mreqB T2a", {7'd0, mreqB}, 8'd0);
      checkOutput("wrA T2a", {7'd0, wrA}, 8'd0);
      applyStimulus(1, M2, T2, 1, 0, 1, 0, 1, 8'h77);
      checkOutput("wrB T2b", {7'd0, wrB}, 8'd0);
      checkOutput("wrA T2b", {7'd0, wrA}, 8'd1);
      applyStimulus(1, M2, T3, 1, 0, 1, 0, 1, 8'h77);
      checkOutput("wrB T3", {7'd0, wrB}, 8'd1);
      checkOutput("diB write", diB, 8'h00);
      checkOutput("diA write", diA, 8'h00);

      // IO read on B with cen toggling: every held clock repeats the previous state.
      applyStimulus(1, M2, T1, 1, 0, 0, 1, 1, 8'hC3);
      checkOutput("cen s1 rd_n", {7'd0, rdB}, 8'd0);
      checkOutput("cen s1 iorq_n", {7'd0, iorqB}, 8'd0);
      checkOutput("cen s1 wait_core_n", {7'd0, wcB}, 8'd0);
      applyStimulus(0, M2, T2, 1, 0, 0, 1, 1, 8'hC3);
      checkOutput("cen s2 rd_n", {7'd0, rdB}, 8'd0);
      checkOutput("cen s2 wait_core_n", {7'd0, wcB}, 8'd0);
      applyStimulus(1, M2, T2, 1, 0, 0, 1, 1, 8'hC3);
      checkOutput("cen s3 rd_n", {7'd0, rdB}, 8'd0);
      checkOutput("cen s3 wait_core_n", {7'd0, wcB}, 8'd1);
      checkOutput("cen s3 di_reg", diB, 8'h00);
      applyStimulus(0, M2, T2, 1, 0, 0, 1, 0, 8'hC3);
      checkOutput("cen s4 wait_core_n follows wait_n", {7'd0, wcB}, 8'd0);
      checkOutput("cen s4 rd_n", {7'd0, rdB}, 8'd0);
      applyStimulus(1, M2, T2, 1, 0, 0, 1, 1, 8'hC3);
      checkOutput("cen s5 rd_n", {7'd0, rdB}, 8'd1);
      checkOutput("cen s5 iorq_n", {7'd0, iorqB}, 8'd1);
      checkOutput("cen s5 mreq_n", {7'd0, mreqB}, 8'd1);
      checkOutput("cen s5 di_reg", diB, 8'hC3);
      applyStimulus(0, M2, T3, 1, 0, 0, 1, 1, 8'h00);
      checkOutput("cen s6 di_reg", diB, 8'hC3);

      // M1 refresh window on B.
      applyStimulus(1, M1, T3, 1, 0, 0, 0, 1, 8'h00);
      applyStimulus(1, M1, T3, 1, 0, 0, 0, 1, 8'h00);
      checkOutput("M1 T3 mreq_n", {7'd0, mreqB}, {7'd0, ~REFRESH});
      checkOutput("M1 T3 rd_n", {7'd0, rdB}, 8'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/tv80_busif.md
# tv80_busif

Parametrised bus-cycle controller that sits between `tv80_core` and the external Z80-style bus. It converts the core's one-hot machine-cycle and T-state outputs into registered `mreq_n`/`iorq_n`/`rd_n`/`wr_n` strobes, and latches read data for the core. It also generates per-cycle-type programmable wait states, merged with the external `wait_n`. Unlike the fixed single-purpose wrapper it replaces, it supports a clock enable, a configurable data width, a write-strobe phase and independent wait counts for opcode fetch, memory, I/O and interrupt-acknowledge cycles.

## Interface
- `DW`, 8: data bus width (bits), for `di`/`di_reg`.
- `T2WRITE`, 1: 1 => `wr_n` active from T2; 0 => `wr_n` active in T3 only.
- `M1_WAIT`, 0: extra wait states for opcode fetch (M1, `intcycle_n`=1), range 0..7.
- `MEM_WAIT`, 0: extra wait states for non-M1 memory cycles, range 0..7.
- `IO_WAIT`, 1: extra wait states for I/O cycles, range 0..7.
- `INTA_WAIT`, 2: extra wait states for interrupt-acknowledge (M1, `intcycle_n`=0), range 0..7.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cen` in 1: clock enable; all state updates only on `clk` edges with `cen`=1.
- `mcycle` in 7: one-hot machine cycle from core (bit0 = M1).
- `tstate` in 7: one-hot T-state from core (bit1 = T1, bit2 = T2, bit3 = T3).
- `intcycle_n` in 1: low during interrupt-acknowledge M1.
- `no_read` in 1: current cycle performs no read.
- `write` in 1: current cycle is a write.
- `iorq` in 1: current non-M1 cycle is I/O.
- `wait_n` in 1: external wait, active-low.
- `di` in DW: external read data.
- `wait_core_n` out 1: combined wait to core.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n` out 1 each: registered bus strobes.
- `di_reg` out DW: latched read data.

## Operation
- Cycle type is decoded when `tstate[1]`=1:
  - FETCH: `mcycle[0]` and `intcycle_n`=1.
  - INTA: `mcycle[0]` and `intcycle_n`=0.
  - IO: not M1, `iorq`=1.
  - MEM: otherwise.
- 3-bit wait counter `wcnt`:
  - On a cen edge with `tstate[1]`=1, `wcnt` loads the type's wait parameter.
  - On a cen edge with `tstate[2]`=1 and `wcnt`≠0, `wcnt` decrements, independent of `wait_n`.
  - All other cen edges hold `wcnt`.
- `wait_core_n` = `wait_n` AND (`wcnt`==0). It is combinational, used by the core only in T2, and holds the core in T2 while low.
- Define `stretch` = `tstate[1]` OR (`tstate[2]` AND `wait_core_n`=0). Each cen edge first sets all strobes high, then applies the rules below.
- M1 cycles (FETCH/INTA): on a cen edge with `stretch`=1:
  - `rd_n`, `mreq_n` <= ~`intcycle_n`.
  - `iorq_n` <= `intcycle_n`.
- Non-M1 read (`no_read`=0, `write`=0), on `stretch`:
  - `rd_n`=0.
  - `iorq_n`=~`iorq`.
  - `mreq_n`=`iorq`.
- Non-M1 write (`write`=1):
  - `T2WRITE`=1: on `stretch`, `wr_n`=0 with the same `iorq_n`/`mreq_n` rule as a read.
  - `T2WRITE`=0: on a cen edge with `tstate[2]`=1, same rule.
- `di_reg` <= `di` on a cen edge with `tstate[2]`=1, `wait_core_n`=1, `write`=0 and `no_read`=0.
- `cen`=0: every register holds. `wait_core_n` still tracks `wait_n` combinationally.

## Timing
- Reset (async, any time, including mid-cycle):
  - `mreq_n`=`iorq_n`=`rd_n`=`wr_n`=1.
  - `di_reg`=0.
  - `wcnt`=0, so `wait_core_n`=`wait_n`.
  - The first cycle after release is a fresh T1.
- Strobe assertion: one cen edge after T1 is sampled, i.e. low for the whole of T2.
- Strobe extent: low through N internal plus external wait clocks. High from the edge that ends the last T2 (start of T3).
- Wait-state count: with N wait states and `wait_n`=1 throughout, T2 lasts N+1 cen cycles.
- External `wait_n` asserted while `wcnt`≠0: stall = max(remaining `wcnt`, external low duration).
- Read data is captured on the same edge the strobes deassert.
- `T2WRITE`=0: `wr_n` is low for exactly the cen cycle following the final T2 edge(s). It is re-asserted while T2 repeats.
- Counter never wraps: decrement only when ≠0. A parameter value >7 is truncated to its 3 LSBs.

## Configuration
- `TV80_BUSIF_REFRESH_EN` defined: in M1 cycles, a cen edge with `tstate[3]`=1 drives `mreq_n`=0, giving a refresh strobe for T3. `rd_n` and `iorq_n` stay high.
- Undefined: `mreq_n` stays high during M1 T3/T4.

## Test plan
- Reset mid-read: assert `reset_n`=0 while `rd_n`=0 in MEM T2 -> all strobes 1, `di_reg`=0 immediately, asynchronously.
- FETCH, `M1_WAIT`=0, `di`=0x3E -> `rd_n`/`mreq_n` low for one T2 cycle, `iorq_n`=1, `di_reg`=0x3E after T2, `wait_core_n` always 1.
- IO read, `IO_WAIT`=3 -> `wait_core_n` low for 3 cen cycles, `iorq_n`/`rd_n` low for 4 cycles, `mreq_n`=1, data latched on 4th edge.
- INTA, `INTA_WAIT`=2, external `wait_n` low 4 cycles starting at T2 -> `iorq_n` low 5 cycles, `mreq_n`/`rd_n` high, `wait_core_n` low 4 cycles.
- MEM write, `T2WRITE`=0 then 1 -> `wr_n` low 1 cycle starting T3 vs low during T2; `di_reg` unchanged in both.
- `cen` toggling 1/0 during IO cycle with `IO_WAIT`=1 -> strobe durations double in `clk` cycles, `wcnt` decrements only on cen edges; with refresh macro, M1 T3 shows `mreq_n`=0, `rd_n`=1.
